regfile_write_ctrl: RTL and testbench



---
 rtl/regfile_write_ctrl_pkg.sv | 15 +
 rtl/regfile_write_ctrl_rr_arb2.sv | 34 +++
 rtl/regfile_write_ctrl.sv | 99 +++++++++
 tb/tb_regfile_write_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_ctrl_pkg.sv
// Shared constants for the register-file write-port controller: FSM state
// encodings, requester ids and default geometry.
package regfile_ctrl_pkg;

  localparam logic CLEAR = 1'b0;
  localparam logic RUN   = 1'b1;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

endpackage

// File: rtl/regfile_write_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// granted last wins; the preference only moves when a grant is accepted.
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic pref;

  // NOTE: every output of a combinational block gets a default first, so
  // no path through it can infer a latch.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = pref ? 2'b10 : 2'b01;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref <= REQ_ALU;
    end else if (advance) begin
      pref <= gnt[REQ_ALU] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Owns the register file write port: clears every register after reset or on
// init_req, otherwise round-robins ALU and load writebacks onto the port.
module regfile_write_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int                 NUM_REGS           = DEF_NUM_REGS,
  parameter int                 ADDR_W             = DEF_ADDR_W,
  parameter int                 DATA_W             = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  INIT_VALUE         = '0,
  parameter bit                 ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] Addr_write,
  output logic [DATA_W-1:0] Data_in,
  output logic              busy
);

  localparam int                CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_REGS - 1);

  logic              state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              issue;

  // Requests are masked during the sweep, so any grant is an accepted handshake.
  assign req = {mem_valid, alu_valid} & {2{state == RUN}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (|gnt),
    .gnt     (gnt)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign mem_ready = gnt[REQ_MEM];
  assign sel_addr  = gnt[REQ_MEM] ? mem_addr : alu_addr;
  assign sel_data  = gnt[REQ_MEM] ? mem_data : alu_data;

  // Writes to a hardwired r0 complete the handshake but never reach the port.
  assign issue = (|gnt) && !(ZERO_REG_HARDWIRED && (sel_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      cnt          <= '0;
      write_enable <= 1'b0;
      Addr_write   <= '0;
      Data_in      <= '0;
      busy         <= 1'b1;
    end else if (state == CLEAR) begin
      busy <= 1'b1;
      if (init_req) begin
        cnt          <= '0;
        write_enable <= 1'b0;
      end else begin
        write_enable <= 1'b1;
        Addr_write   <= ADDR_W'(cnt);
        Data_in      <= INIT_VALUE;
        if (cnt == LAST) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end else begin
      // A grant in the init_req cycle still takes the next write slot; the
      // sweep naturally begins one cycle later.
      write_enable <= issue;
      if (issue) begin
        Addr_write <= sel_addr;
        Data_in    <= sel_data;
      end
      busy <= init_req;
      if (init_req) begin
        state <= CLEAR;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: clear sweeps, single and contended
// writebacks, hardwired r0, init_req with a pending grant, async reset mid-sweep.
module tb_regfile_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic        init_req;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        write_enable;
  logic [4:0]  Addr_write;
  logic [31:0] Data_in;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_req     (init_req),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .write_enable (write_enable),
    .Addr_write   (Addr_write),
    .Data_in      (Data_in),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_sweep(input string tag);
    for (int k = 0; k < 32; k++) begin
      step();
      check($sformatf("%s_we%0d", tag, k), 32'(write_enable), 32'd1);
      check($sformatf("%s_addr%0d", tag, k), 32'(Addr_write), 32'(k));
      check($sformatf("%s_data%0d", tag, k), Data_in, 32'd0);
      check($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    init_req  = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;

    // Reset state, then the power-on sweep.
    @(negedge clk);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_addr", 32'(Addr_write), 32'd0);
    check("rst_data", Data_in, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    check_sweep("por");
    step();
    check("por_end_we", 32'(write_enable), 32'd0);
    check("por_end_busy", 32'(busy), 32'd0);

    // Single ALU writeback.
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("alu_ready", 32'(alu_ready), 32'd1);
    check("alu_mem_ready", 32'(mem_ready), 32'd0);
    step();
    alu_valid = 1'b0;
    check("alu_we", 32'(write_enable), 32'd1);
    check("alu_addr", 32'(Addr_write), 32'd5);
    check("alu_data", Data_in, 32'hDEADBEEF);
    step();
    check("alu_idle_we", 32'(write_enable), 32'd0);
    check("alu_idle_addr_hold", 32'(Addr_write), 32'd5);

    // Load to hardwired r0: accepted, never written.
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h55;
    #1;
    check("r0_ready", 32'(mem_ready), 32'd1);
    step();
    mem_valid = 1'b0;
    check("r0_we", 32'(write_enable), 32'd0);
    check("r0_addr_hold", 32'(Addr_write), 32'd5);
    check("r0_data_hold", Data_in, 32'hDEADBEEF);

    // Both valid for four cycles: last grant was MEM, so ALU leads.
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_alu_ready%0d", i), 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_mem_ready%0d", i), 32'(mem_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check($sformatf("rr_we%0d", i), 32'(write_enable), 32'd1);
      check($sformatf("rr_addr%0d", i), 32'(Addr_write), (i % 2 == 0) ? 32'd3 : 32'd7);
      check($sformatf("rr_data%0d", i), Data_in, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    check("rr_idle_we", 32'(write_enable), 32'd0);

    // init_req with a simultaneous ALU grant; a load waits through the sweep.
    init_req = 1'b1; alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    #1;
    check("init_alu_ready", 32'(alu_ready), 32'd1);
    step();
    init_req = 1'b0; alu_valid = 1'b0;
    check("init_grant_we", 32'(write_enable), 32'd1);
    check("init_grant_addr", 32'(Addr_write), 32'd9);
    check("init_grant_data", Data_in, 32'h99);
    check("init_grant_busy", 32'(busy), 32'd1);
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h77;
    #1;
    check("init_mem_ready_pre", 32'(mem_ready), 32'd0);
    for (int k = 0; k < 32; k++) begin
      step();
      check($sformatf("init_we%0d", k), 32'(write_enable), 32'd1);
      check($sformatf("init_addr%0d", k), 32'(Addr_write), 32'(k));
      check($sformatf("init_data%0d", k), Data_in, 32'd0);
      check($sformatf("init_busy%0d", k), 32'(busy), 32'd1);
      // The last sweep write is already presented in RUN, so the load is taken then.
      check($sformatf("init_mem_ready%0d", k), 32'(mem_ready), (k == 31) ? 32'd1 : 32'd0);
    end
    step();
    mem_valid = 1'b0;
    check("post_init_we", 32'(write_enable), 32'd1);
    check("post_init_addr", 32'(Addr_write), 32'd4);
    check("post_init_data", Data_in, 32'h77);
    check("post_init_busy", 32'(busy), 32'd0);
    step();
    check("post_init_idle_we", 32'(write_enable), 32'd0);

    // Async reset at sweep count 12, then a full restarted sweep.
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    check("rs_start_we", 32'(write_enable), 32'd0);
    check("rs_start_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 12; k++) step();
    check("rs_mid_addr", 32'(Addr_write), 32'd11);
    check("rs_mid_we", 32'(write_enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_async_we", 32'(write_enable), 32'd0);
    check("rs_async_addr", 32'(Addr_write), 32'd0);
    check("rs_async_data", Data_in, 32'd0);
    check("rs_async_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("rs");
    step();
    check("rs_end_we", 32'(write_enable), 32'd0);
    check("rs_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
